// File: rtl/sp_rd_pkg.sv
// Shared definitions for the SuperMario readout receiver: default geometry,
// packer state encoding and the slots-per-word helper.
package sp_rd_pkg;

  localparam int SP_LANES_DEF  = 8;
  localparam int SP_WORD_W_DEF = 32;

  typedef enum logic [0:0] {
    PK_OFF  = 1'b0,
    PK_FILL = 1'b1
  } pack_state_t;

  function automatic int sp_slots(input int out_w, input int lanes);
    return out_w / lanes;
  endfunction

endpackage

// File: rtl/sp_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO; the head word is visible
// on rd_data whenever empty is low, and reads zero while empty.
module sp_sync_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == LVL_W'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

  // A pop in the same cycle frees the slot, so a write at full still lands.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // NOTE: storage is deliberately not reset; rd_data is gated by empty, so
  // stale contents are never observable and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: all state updates use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sp_rd_lvds_pack.sv
// SuperMario readout receiver: polarity-corrects and synchronises the LVDS
// lanes, packs samples into words on update strobes and queues them in a FIFO.
module sp_rd_lvds_pack
  import sp_rd_pkg::*;
#(
  parameter int               LANES       = SP_LANES_DEF,
  parameter int               OUT_W       = SP_WORD_W_DEF,
  parameter int               FIFO_DEPTH  = 16,
  parameter logic [LANES-1:0] INV_MASK    = {LANES{1'b1}},
  parameter logic             INV_CTRL    = 1'b1,
  parameter int               SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          clr,
  input  logic [LANES-1:0]              lane_in,
  input  logic                          update_in,
  input  logic                          eof_in,
  output logic [OUT_W-1:0]              dout,
  output logic                          dout_last,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          overflow,
  output logic [15:0]                   frame_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int SLOTS  = sp_slots(OUT_W, LANES);
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

  logic [LANES-1:0]       lane_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] upd_sync;
  logic [SYNC_STAGES-1:0] eof_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_sync <= '{default: '0};
      upd_sync  <= '0;
      eof_sync  <= '0;
    end else begin
      lane_sync[0] <= lane_in ^ INV_MASK;
      for (int i = 1; i < SYNC_STAGES; i++) lane_sync[i] <= lane_sync[i-1];
      upd_sync <= {upd_sync[SYNC_STAGES-2:0], update_in ^ INV_CTRL};
      eof_sync <= {eof_sync[SYNC_STAGES-2:0], eof_in ^ INV_CTRL};
    end
  end

  // lane_smp is delayed alongside the event so the sample lines up with it.
  logic             upd_prev;
  logic             eof_prev;
  logic             upd_ev;
  logic             eof_ev;
  logic [LANES-1:0] lane_smp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_prev <= 1'b0;
      eof_prev <= 1'b0;
      upd_ev   <= 1'b0;
      eof_ev   <= 1'b0;
      lane_smp <= '0;
    end else begin
      upd_prev <= upd_sync[SYNC_STAGES-1];
      eof_prev <= eof_sync[SYNC_STAGES-1];
      upd_ev   <= upd_sync[SYNC_STAGES-1] && !upd_prev;
      eof_ev   <= eof_sync[SYNC_STAGES-1] && !eof_prev;
      lane_smp <= lane_sync[SYNC_STAGES-1];
    end
  end

  pack_state_t       state;
  logic [OUT_W-1:0]  shreg;
  logic [SLOT_W-1:0] slot;
  logic [OUT_W-1:0]  word_ins;
  logic              word_full;
  logic              push_valid;
  logic [OUT_W-1:0]  push_data;
  logic              push_last;

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    word_ins  = shreg;
    word_full = 1'b0;
    if (upd_ev) begin
      word_ins  = shreg | (OUT_W'(lane_smp) << (slot * LANES));
      word_full = (slot == SLOT_W'(SLOTS - 1));
    end
  end

  // Upper slots of shreg are always zero, which gives eof its zero padding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PK_OFF;
      shreg      <= '0;
      slot       <= '0;
      push_valid <= 1'b0;
      push_data  <= '0;
      push_last  <= 1'b0;
    end else begin
      push_valid <= 1'b0;
      if (!en) begin
        state <= PK_OFF;
        shreg <= '0;
        slot  <= '0;
      end else if (state == PK_OFF) begin
        state <= PK_FILL;
      end else if (eof_ev || word_full) begin
        push_valid <= 1'b1;
        push_data  <= word_ins;
        push_last  <= eof_ev;
        shreg      <= '0;
        slot       <= '0;
      end else if (upd_ev) begin
        shreg <= word_ins;
        slot  <= slot + 1'b1;
      end
    end
  end

  logic [OUT_W:0] fifo_rd_data;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_pop;
  logic           push_ok;

  sp_sync_fifo #(
    .W     (OUT_W + 1),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push_valid),
    .wr_data ({push_last, push_data}),
    .rd_en   (dout_ready),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign fifo_pop   = dout_ready && !fifo_empty;
  assign push_ok    = push_valid && (!fifo_full || fifo_pop);
  assign dout       = fifo_rd_data[OUT_W-1:0];
  assign dout_last  = fifo_rd_data[OUT_W];
  assign dout_valid = !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else if (clr) begin
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (push_valid && !push_ok) overflow  <= 1'b1;
      if (push_ok && push_last)   frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule
